// File: rtl/stack_sequencer.sv
// Stack pointer sequencer for multi-byte push/pull operations.
// Each byte is an address phase (SP drives the low address byte, the
// stack page goes on the high address byte, memory strobe) and an adjust
// phase (this block drives SP+/-1 onto the stack bus and SP reloads it).
// Pulls first sample SP so that the pre-increment happens before the
// first access; pushes access first and post-decrement.
module stack_sequencer #(
    parameter logic [7:0]  STACK_PAGE = 8'h01,
    parameter int unsigned MAX_COUNT  = 3
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       cmdValid,
    input  logic       cmdPull,
    input  logic [1:0] cmdCount,
    output logic       cmdReady,
    output logic       busy,
    output logic       spStackBusWriteEnable,
    output logic       spStackBusReadEnable,
    output logic       spAddressBusLowWriteEnable,
    input  logic [7:0] stackBusInput,
    output logic [7:0] stackBusOutput,
    output logic [7:0] addressBusHighOutput,
    output logic       memWriteStrobe,
    output logic       memReadStrobe,
    output logic [1:0] byteIndex,
    output logic       done,
    output logic       stackWrap
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SAMPLE = 2'd1,
        S_ACCESS = 2'd2,
        S_ADJUST = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] latch_q, latch_d;
    logic [1:0] remaining_q, remaining_d;
    logic [1:0] index_q, index_d;
    logic       pull_q, pull_d;

    logic       cmd_legal_s;
    logic       last_s;
    logic [7:0] adjusted_s;
    logic       drive_stack_s;
    logic       drive_page_s;

    // Zero-length and over-long requests are silently dropped in IDLE.
    assign cmd_legal_s = (cmdCount != 2'd0) && (32'(cmdCount) <= MAX_COUNT);
    assign last_s      = (remaining_q == 2'd1);
    assign adjusted_s  = pull_q ? (latch_q + 8'd1) : (latch_q - 8'd1);

    // Next-state logic: command capture, byte counting and phase ordering.
    always_comb begin
        state_d     = state_q;
        latch_d     = latch_q;
        remaining_d = remaining_q;
        index_d     = index_q;
        pull_d      = pull_q;
        case (state_q)
            S_IDLE: begin
                if (cmdValid && cmd_legal_s) begin
                    pull_d      = cmdPull;
                    remaining_d = cmdCount;
                    index_d     = 2'd0;
                    state_d     = cmdPull ? S_SAMPLE : S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SAMPLE: begin
                latch_d = stackBusInput;
                state_d = S_ADJUST;
            end
            S_ACCESS: begin
                latch_d = stackBusInput;
                if (pull_q) begin
                    // A pull byte completes on its data-read access.
                    if (last_s) begin
                        remaining_d = 2'd0;
                        index_d     = 2'd0;
                        state_d     = S_IDLE;
                    end else begin
                        remaining_d = remaining_q - 2'd1;
                        index_d     = index_q + 2'd1;
                        state_d     = S_ADJUST;
                    end
                end else begin
                    state_d = S_ADJUST;
                end
            end
            S_ADJUST: begin
                if (!pull_q) begin
                    // A push byte completes on its post-decrement.
                    if (last_s) begin
                        remaining_d = 2'd0;
                        index_d     = 2'd0;
                        state_d     = S_IDLE;
                    end else begin
                        remaining_d = remaining_q - 2'd1;
                        index_d     = index_q + 2'd1;
                        state_d     = S_ACCESS;
                    end
                end else begin
                    state_d = S_ACCESS;
                end
            end
            default: begin
                state_d     = S_IDLE;
                remaining_d = 2'd0;
                index_d     = 2'd0;
            end
        endcase
    end

    // State register; reset abandons any command in flight immediately.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            latch_q     <= 8'h00;
            remaining_q <= 2'd0;
            index_q     <= 2'd0;
            pull_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            latch_q     <= latch_d;
            remaining_q <= remaining_d;
            index_q     <= index_d;
            pull_q      <= pull_d;
        end
    end

    // Output decode from registered state only; SP drives the stack bus in
    // SAMPLE/ACCESS and this block drives it only in ADJUST, so they never
    // contend.
    always_comb begin
        cmdReady                   = 1'b0;
        busy                       = 1'b1;
        spStackBusWriteEnable      = 1'b0;
        spStackBusReadEnable       = 1'b0;
        spAddressBusLowWriteEnable = 1'b0;
        memWriteStrobe             = 1'b0;
        memReadStrobe              = 1'b0;
        done                       = 1'b0;
        stackWrap                  = 1'b0;
        drive_stack_s              = 1'b0;
        drive_page_s               = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmdReady = 1'b1;
                busy     = 1'b0;
            end
            S_SAMPLE: begin
                spStackBusWriteEnable = 1'b1;
            end
            S_ACCESS: begin
                spStackBusWriteEnable      = 1'b1;
                spAddressBusLowWriteEnable = 1'b1;
                drive_page_s               = 1'b1;
                memWriteStrobe             = !pull_q;
                memReadStrobe              = pull_q;
                done                       = pull_q && last_s;
            end
            S_ADJUST: begin
                spStackBusReadEnable = 1'b1;
                drive_stack_s        = 1'b1;
                done                 = !pull_q && last_s;
                stackWrap            = pull_q ? (latch_q == 8'hFF) : (latch_q == 8'h00);
            end
            default: begin
                cmdReady = 1'b0;
                busy     = 1'b1;
            end
        endcase
    end

    assign byteIndex            = index_q;
    assign stackBusOutput       = drive_stack_s ? adjusted_s : 8'bzzzzzzzz;
    assign addressBusHighOutput = drive_page_s  ? STACK_PAGE : 8'bzzzzzzzz;

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Sequences the stack pointer register for multi-byte stack operations: push/pull of 1-3 bytes (PHA/PLA, JSR/RTS, BRK/IRQ/RTI).
- Each byte needs an address phase (SP drives ABL, page 0x01 on ABH, memory strobe) and an adjust phase (controller drives SP±1 onto the stack bus, SP loads it).
- Sits between the instruction decoder and the SP register / address-bus high mux.
- Never drives the stack bus in the same cycle the SP register drives it.

Parameters:
STACK_PAGE, 8'h01, value driven on addressBusHighOutput during access cycles
MAX_COUNT, 3, largest legal byte count per command

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
cmdValid  input  1  command request
cmdPull  input  1  0 = push (post-decrement), 1 = pull (pre-increment)
cmdCount  input  2  bytes to transfer, 1..MAX_COUNT; 0 is illegal
cmdReady  output  1  high only in IDLE; command accepted when cmdValid&cmdReady
busy  output  1  high in every non-IDLE state
spStackBusWriteEnable  output  1  to SP stackBusWriteEnable
spStackBusReadEnable  output  1  to SP stackBusReadEnable
spAddressBusLowWriteEnable  output  1  to SP addressBusLowWriteEnable
stackBusInput  input  8  stack bus value (sampled when SP drives it)
stackBusOutput  output  8  adjusted SP value; 8'bz when not driving
addressBusHighOutput  output  8  STACK_PAGE during ACCESS; 8'bz otherwise
memWriteStrobe  output  1  push data-write cycle
memReadStrobe  output  1  pull data-read cycle
byteIndex  output  2  0-based index of current byte (0 in IDLE)
done  output  1  one-cycle pulse in the final cycle of a command
stackWrap  output  1  one-cycle pulse when an adjust wraps (00->FF push, FF->00 pull)

Behaviour:
- Reset (async, nrst low): state IDLE, latch=8'h00, remaining=0, byteIndex=0. All enables, strobes, done and stackWrap at 0. stackBusOutput and addressBusHighOutput at z. Reset mid-command abandons it immediately; SP keeps whatever it last loaded.
- States: IDLE, SAMPLE, ACCESS, ADJUST.
- IDLE: cmdReady=1. On cmdValid with cmdCount in 1..MAX_COUNT, capture op and count, then:
  - push -> ACCESS
  - pull -> SAMPLE
  - cmdValid with cmdCount=0 or >MAX_COUNT: ignored; stay IDLE, no pulses.
- SAMPLE (pull only): spStackBusWriteEnable=1; latch<=stackBusInput; next ADJUST.
- ACCESS:
  - spAddressBusLowWriteEnable=1, spStackBusWriteEnable=1; addressBusHighOutput=STACK_PAGE; latch<=stackBusInput.
  - Push: memWriteStrobe=1; next ADJUST.
  - Pull: memReadStrobe=1; byte counts complete. If last byte: done=1, next IDLE. Else byteIndex++ and next ADJUST.
- ADJUST:
  - stackBusOutput = latch-1 (push) or latch+1 (pull), 8-bit modulo; spStackBusReadEnable=1; SP write enable must be 0.
  - stackWrap=1 if push with latch==8'h00, or pull with latch==8'hFF.
  - Push: byte counts complete. If last byte: done=1, next IDLE. Else byteIndex++ and next ACCESS.
  - Pull: next ACCESS.
- Latency:
  - push n bytes = 2n cycles from acceptance to IDLE (ACCESS/ADJUST pairs);
  - pull n bytes = 1+2n cycles (SAMPLE, then ADJUST/ACCESS pairs).
- Invariant: spStackBusWriteEnable and spStackBusReadEnable are never both 1. stackBusOutput is non-z only in ADJUST.
- Commands arriving while busy are not accepted (cmdReady=0); the requester holds cmdValid.
- Outputs are combinational decode of the registered state and latch; no output depends combinationally on cmdValid except cmdReady (state-only).

Test Plan:
- Reset: hold nrst low mid-push -> all enables/strobes 0, buses z, cmdReady=1 in the same cycle, without waiting for a clock edge.
- Push 1 byte, SP=8'hFD:
  - cycle 0: ACCESS with ABL enable and ABH=8'h01;
  - cycle 1: stackBusOutput=8'hFC, read enable, done=1;
  - SP reads 8'hFC afterwards.
- Push 3 (IRQ), SP=8'hFF: SP steps FE, FD, FC; byteIndex 0,1,2; six cycles; done only in cycle 5; memWriteStrobe on cycles 0, 2, 4.
- Pull 2 (RTS), SP=8'hFB: SAMPLE, then ADJUST->FC, ACCESS, ADJUST->FD, ACCESS(done); five cycles; memReadStrobe on cycles 2 and 4 with ABL=FC then FD.
- Wrap cases:
  - push 1 at SP=8'h00 -> stackBusOutput=8'hFF, stackWrap pulse;
  - pull 1 at SP=8'hFF -> 8'h00, stackWrap pulse.
- Illegal and back-to-back commands:
  - cmdCount=0 -> no state change, no pulses;
  - cmdValid held during busy -> accepted only in the cycle after done;
  - bus enables never overlap throughout.
